// File: rtl/cluster_sync_pkg.sv
// Shared encodings for the cluster readout path.
// Used by cluster_evt_reader and the cluster sync arbiter.
package cluster_sync_pkg;

  typedef enum logic [1:0] {
    WAIT = 2'd0,
    TX   = 2'd1,
    DROP = 2'd2
  } evt_ctrl_e;

  typedef enum logic [1:0] {
    E_NOT_AV = 2'd0,
    EHDR_AV  = 2'd1,
    M_AV     = 2'd2,
    EFTR_AV  = 2'd3
  } evt_av_e;

  typedef enum logic [2:0] {
    W_DATA,
    W_HDR,
    W_MOD,
    W_FTR,
    W_RSV
  } word_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_MOD,
    S_FTR,
    S_GAP
  } cer_state_e;

  // Offsets from the word MSB: flag, then the 2-bit tag.
  localparam int FLAG_OFS   = 1;
  localparam int TAG_HI_OFS = 2;
  localparam int TAG_LO_OFS = 3;

  localparam logic [1:0] TAG_HDR = 2'b01;
  localparam logic [1:0] TAG_MOD = 2'b10;
  localparam logic [1:0] TAG_FTR = 2'b11;

  function automatic word_e word_type(
    input logic       flag,
    input logic [1:0] tag
  );
    word_e t;
    t = W_RSV;
    if (!flag) begin
      t = W_DATA;
    end else begin
      unique case (tag)
        TAG_HDR: t = W_HDR;
        TAG_MOD: t = W_MOD;
        TAG_FTR: t = W_FTR;
        default: t = W_RSV;
      endcase
    end
    return t;
  endfunction

endpackage

// File: rtl/cluster_evt_reader_if.sv
// FIFO, arbiter and downstream signals of one cluster reader.
// master = reader side, slave = FIFO/arbiter/sink side.
interface cluster_evt_reader_if #(
  parameter int DATA_WIDTH   = 65,
  parameter int EVT_HDR_BITS = 40
);
  logic [DATA_WIDTH-1:0]   fifo_dout;
  logic                    fifo_empty;
  logic                    fifo_rd_en;
  logic [1:0]              evt_available;
  logic [EVT_HDR_BITS-1:0] evt_l0id;
  logic [1:0]              evt_ctrl;
  logic [DATA_WIDTH-1:0]   out_data;
  logic                    out_valid;
  logic                    out_ready;

  modport master (
    input  fifo_dout, fifo_empty, evt_ctrl, out_ready,
    output fifo_rd_en, evt_available, evt_l0id,
    output out_data, out_valid
  );

  modport slave (
    output fifo_dout, fifo_empty, evt_ctrl, out_ready,
    input  fifo_rd_en, evt_available, evt_l0id,
    input  out_data, out_valid
  );
endinterface

// File: rtl/cer_head_stage.sv
// One-entry head register in front of an FWFT FIFO.
// Refills in the same cycle the current word is popped.
module cer_head_stage #(
  parameter int DATA_WIDTH = 65
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic [DATA_WIDTH-1:0] fifo_dout_i,
  input  logic                  fifo_empty_i,
  input  logic                  pop_i,
  output logic                  fifo_rd_en_o,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o
);
  logic                  valid_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  load;

  assign load = ~srst & ~fifo_empty_i & (~valid_q | pop_i);

  assign fifo_rd_en_o = load;
  assign valid_o      = valid_q;
  assign data_o       = data_q;

  always_ff @(posedge clk) begin
    if (srst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (load) begin
      valid_q <= 1'b1;
      data_q  <= fifo_dout_i;
    end else if (pop_i) begin
      valid_q <= 1'b0;
    end
  end
endmodule

// File: rtl/cluster_evt_reader.sv
// Per-cluster event reader: parses the FIFO stream into segments.
// Optional footer/header L0ID compare under `CER_L0ID_CHECK_EN.
module cluster_evt_reader
  import cluster_sync_pkg::*;
#(
  parameter int DATA_WIDTH   = 65,
  parameter int EVT_HDR_BITS = 40,
  parameter int GAP_CYCLES   = 2,
  parameter int ERR_CNT_BITS = 16
) (
  input  logic                    clk,
  input  logic                    srst,
  cluster_evt_reader_if.master    evt_if,
  output logic [ERR_CNT_BITS-1:0] err_cnt
`ifdef CER_L0ID_CHECK_EN
  ,
  output logic                    l0id_mismatch
`endif
);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  logic                    head_v;
  logic [DATA_WIDTH-1:0]   head_d;
  word_e                   wt;
  logic                    tx, drop, disp, seg_go;
  logic                    pop, ovld, done, err_inc;

  cer_state_e              state_q;
  evt_av_e                 av_q;
  logic [EVT_HDR_BITS-1:0] l0id_q;
  logic [GW-1:0]           gap_q;
  logic                    first_q;
  logic                    in_evt_q;
  logic [ERR_CNT_BITS-1:0] err_q;

  cer_head_stage #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_head (
    .clk          (clk),
    .srst         (srst),
    .fifo_dout_i  (evt_if.fifo_dout),
    .fifo_empty_i (evt_if.fifo_empty),
    .pop_i        (pop),
    .fifo_rd_en_o (evt_if.fifo_rd_en),
    .valid_o      (head_v),
    .data_o       (head_d)
  );

  assign wt = word_type(
    head_d[DATA_WIDTH-FLAG_OFS],
    head_d[DATA_WIDTH-TAG_HI_OFS:DATA_WIDTH-TAG_LO_OFS]);

  assign tx   = (evt_if.evt_ctrl == TX);
  assign drop = (evt_if.evt_ctrl == DROP);

  // The last GAP cycle dispatches directly so the gap is exact.
  assign disp = head_v &
    ((state_q == S_IDLE) |
     ((state_q == S_GAP) & (gap_q == '0)));

  assign seg_go = disp &
    ((wt == W_HDR) | (wt == W_MOD) | (wt == W_FTR));

`ifdef CER_L0ID_CHECK_EN
  logic mism, mism_q;
  assign mism = (state_q == S_FTR) & done &
    (head_d[EVT_HDR_BITS-1:0] != l0id_q);
`endif

  always_comb begin
    pop     = 1'b0;
    ovld    = 1'b0;
    done    = 1'b0;
    err_inc = 1'b0;
    unique case (state_q)
      S_IDLE, S_GAP: begin
        if (disp) begin
          if (wt == W_DATA || wt == W_RSV) begin
            pop     = 1'b1;
            err_inc = 1'b1;
          end else if (wt == W_HDR) begin
            err_inc = in_evt_q;
          end
        end
      end
      S_HDR, S_FTR: begin
        if (head_v) begin
          ovld = tx;
          if ((tx & evt_if.out_ready) | drop) begin
            pop  = 1'b1;
            done = 1'b1;
          end
        end
      end
      S_MOD: begin
        if (head_v) begin
          if (first_q | ~head_d[DATA_WIDTH-FLAG_OFS]) begin
            ovld = tx;
            pop  = (tx & evt_if.out_ready) | drop;
          end else begin
            done    = 1'b1;
            err_inc = (wt == W_HDR);
          end
        end
      end
      default: ;
    endcase
`ifdef CER_L0ID_CHECK_EN
    if (mism) err_inc = 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q  <= S_IDLE;
      av_q     <= E_NOT_AV;
      l0id_q   <= '0;
      gap_q    <= '0;
      first_q  <= 1'b0;
      in_evt_q <= 1'b0;
      err_q    <= '0;
    end else begin
      if (err_inc && err_q != '1) err_q <= err_q + 1'b1;
      if (pop) first_q <= 1'b0;
      if (done) begin
        state_q <= S_GAP;
        av_q    <= E_NOT_AV;
        gap_q   <= GW'(GAP_CYCLES - 1);
        if (state_q == S_HDR) in_evt_q <= 1'b1;
        else if (state_q == S_FTR || wt == W_HDR)
          in_evt_q <= 1'b0;
      end else if (seg_go) begin
        unique case (wt)
          W_HDR: begin
            state_q <= S_HDR;
            av_q    <= EHDR_AV;
            l0id_q  <= head_d[EVT_HDR_BITS-1:0];
          end
          W_MOD: begin
            state_q <= S_MOD;
            av_q    <= M_AV;
            first_q <= 1'b1;
          end
          default: begin
            state_q <= S_FTR;
            av_q    <= EFTR_AV;
          end
        endcase
      end else if (state_q == S_GAP) begin
        if (gap_q == '0) state_q <= S_IDLE;
        else gap_q <= gap_q - 1'b1;
      end
    end
  end

`ifdef CER_L0ID_CHECK_EN
  always_ff @(posedge clk) begin
    if (srst) mism_q <= 1'b0;
    else if (mism) mism_q <= 1'b1;
  end
  assign l0id_mismatch = mism_q;
`endif

  assign evt_if.evt_available = av_q;
  assign evt_if.evt_l0id      = l0id_q;
  assign evt_if.out_data      = head_d;
  assign evt_if.out_valid     = ovld;
  assign err_cnt              = err_q;
endmodule

// File: tb/tb_cluster_evt_reader.sv
// Bench for cluster_evt_reader: segment-level model plus random arbiter.
// Build with +define+CER_L0ID_CHECK_EN to cover the L0ID compare.
module tb_cluster_evt_reader;
  import cluster_sync_pkg::*;

  localparam int DW = 65;
  localparam int HB = 40;
  localparam int GC = 2;
  localparam int EB = 16;

  logic clk = 1'b0;
  logic srst = 1'b1;
  always #5 clk = ~clk;

  cluster_evt_reader_if #(.DATA_WIDTH(DW), .EVT_HDR_BITS(HB)) bus ();
  logic [EB-1:0] err_cnt;
`ifdef CER_L0ID_CHECK_EN
  logic l0id_mismatch;
`endif

  cluster_evt_reader #(
    .DATA_WIDTH(DW), .EVT_HDR_BITS(HB),
    .GAP_CYCLES(GC), .ERR_CNT_BITS(EB)
  ) dut (
    .clk(clk),
    .srst(srst),
    .evt_if(bus),
`ifdef CER_L0ID_CHECK_EN
    .l0id_mismatch(l0id_mismatch),
`endif
    .err_cnt(err_cnt)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [64:0] got,
                     input logic [64:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {int typ; int st; int len;} seg_t;
  logic [64:0] fq[$];
  logic [64:0] wmem[0:8191];
  int          wptr;
  seg_t        segq[$];
  int          m_err;
  bit          m_in_mod, m_in_evt, m_mism;
  logic [39:0] m_l0id;
  int          pol_wait[$];
  int          pol_act[$];

  function automatic logic [64:0] mkw(input logic [1:0] tg,
                                      input logic [39:0] l0);
    return {1'b1, tg, 22'd0, l0};
  endfunction

  function automatic logic [64:0] mkd(input logic [63:0] d);
    return {1'b0, d};
  endfunction

  task automatic add_seg(input int typ, input logic [64:0] w);
    seg_t s;
    s.typ = typ; s.st = wptr; s.len = 1;
    segq.push_back(s);
    wmem[wptr] = w;
    wptr++;
  endtask

  task automatic feed(input logic [64:0] w);
    int li;
    fq.push_back(w);
    if (!w[64]) begin
      if (m_in_mod) begin
        li = segq.size() - 1;
        wmem[wptr] = w;
        wptr++;
        segq[li].len = segq[li].len + 1;
      end else m_err++;
    end else begin
      case (w[63:62])
        2'b01: begin
          if (m_in_mod || m_in_evt) m_err++;
          add_seg(1, w);
          m_in_mod = 0; m_in_evt = 1; m_l0id = w[39:0];
        end
        2'b10: begin add_seg(2, w); m_in_mod = 1; end
        2'b11: begin
          add_seg(3, w);
          m_in_mod = 0; m_in_evt = 0;
`ifdef CER_L0ID_CHECK_EN
          if (w[39:0] != m_l0id) begin m_err++; m_mism = 1; end
`endif
        end
        default: begin m_err++; m_in_mod = 0; end
      endcase
    end
  endtask

  task automatic feed_mod(input int nd);
    feed(mkw(2'b10, 40'($urandom)));
    for (int i = 0; i < nd; i++) feed(mkd({$urandom, $urandom}));
  endtask

  task automatic pol(input int k, input int a);
    pol_wait.push_back(k);
    pol_act.push_back(a);
  endtask

  // ---------------- arbiter / sink / FIFO driver ----------------
  bit          active, seen_end, prev_stall;
  seg_t        cur;
  int          k_wait, act, cyc, idx, gap_run;
  logic [64:0] prev_data;

  task automatic clear_tb();
    fq.delete(); segq.delete(); pol_wait.delete(); pol_act.delete();
    wptr = 0; m_err = 0; m_in_mod = 0; m_in_evt = 0;
    m_mism = 0; m_l0id = '0;
    active = 0; seen_end = 0; prev_stall = 0; gap_run = 0;
  endtask

  task automatic run(input int max_cyc, input bit bub,
                     input bit exact_gap, input bit rrdy, input bit brk);
    int quiet;
    int n;
    logic [1:0] av;
    quiet = 0;
    n = 0;
    while (quiet < GC + 4 && n < max_cyc) begin
      @(negedge clk);
      n++;
      av = bus.evt_available;
      if (!active && av != 2'd0) begin
        if (seen_end) begin
          if (exact_gap) chk("gap_len", 65'(gap_run), 65'(GC));
          else chk("gap_min", 65'(gap_run >= GC), 65'd1);
        end
        if (segq.size() == 0) chk("seg_unexpected", 65'(av), 65'd0);
        else begin
          cur = segq.pop_front();
          chk("seg_type", 65'(av), 65'(cur.typ));
          if (cur.typ == 1)
            chk("l0id", 65'(bus.evt_l0id), 65'(wmem[cur.st][39:0]));
          active = 1; idx = 0; cyc = 0;
          if (pol_act.size() != 0) begin
            k_wait = pol_wait.pop_front();
            act = pol_act.pop_front();
          end else begin
            k_wait = $urandom_range(0, 3);
            act = ($urandom_range(0, 2) != 0) ? 1 : 2;
          end
        end
      end else if (active && av == 2'd0) begin
        chk("beats", 65'(idx), 65'((act == 1) ? cur.len : 0));
        if (cur.typ != 2 && act == 2)
          chk("drop_cycles", 65'(cyc), 65'(k_wait + 1));
        active = 0; seen_end = 1; gap_run = 0;
      end else if (active) begin
        chk("av_hold", 65'(av), 65'(cur.typ));
      end
      if (!active && av == 2'd0) gap_run++;

      if (active) begin
        if (cyc < k_wait)
          bus.evt_ctrl = ($urandom_range(0, 1) != 0) ? 2'd3 : 2'd0;
        else bus.evt_ctrl = 2'(act);
        cyc++;
      end else bus.evt_ctrl = 2'($urandom_range(0, 3));
      bus.out_ready = rrdy ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.fifo_empty = (fq.size() == 0) ||
                       (bub && $urandom_range(0, 4) == 0);
      bus.fifo_dout = (fq.size() != 0) ? fq[0] : '0;
      #1;
      if (prev_stall) begin
        chk("stall_valid", 65'(bus.out_valid), 65'd1);
        chk("stall_data", bus.out_data, prev_data);
      end
      if (bus.out_valid) begin
        chk("valid_tx", 65'(active && bus.evt_ctrl == 2'd1), 65'd1);
        if (bus.out_ready) begin
          chk("beat_in_seg", 65'(active && idx < cur.len), 65'd1);
          if (active && idx < cur.len)
            chk("beat_data", bus.out_data, wmem[cur.st + idx]);
          idx++;
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data = bus.out_data;
      if (bus.fifo_rd_en) begin
        chk("rd_en_nonempty", 65'(bus.fifo_empty), 65'd0);
        if (!bus.fifo_empty) void'(fq.pop_front());
      end
      if (brk && active && cur.typ == 2 && idx >= 2) break;
      if (fq.size() == 0 && segq.size() == 0 && !active) quiet++;
      else quiet = 0;
    end
    if (!brk) chk("timeout", 65'(quiet), 65'(GC + 4));
  endtask

  initial begin
    bit nofoot;
    int r;
    logic [39:0] l0;
    clear_tb();
    bus.evt_ctrl = 2'd1;
    bus.out_ready = 1'b1;
    bus.fifo_empty = 1'b0;
    bus.fifo_dout = mkw(2'b01, 40'h12);
    srst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_rd_en", 65'(bus.fifo_rd_en), 65'd0);
    chk("rst_av", 65'(bus.evt_available), 65'd0);
    chk("rst_l0id", 65'(bus.evt_l0id), 65'd0);
    chk("rst_valid", 65'(bus.out_valid), 65'd0);
    chk("rst_data", bus.out_data, 65'd0);
    chk("rst_err", 65'(err_cnt), 65'd0);
    @(negedge clk);
    bus.fifo_empty = 1'b1;
    srst = 1'b0;

    // Directed event flow with exact gap checks.
    feed(mkw(2'b01, 40'h12)); pol(0, 1);
    feed(mkw(2'b11, 40'h12)); pol(0, 1);
    feed(mkw(2'b01, 40'h34)); pol(0, 2);
    feed_mod(3);              pol(1, 1);
    feed_mod(2);              pol(2, 1);
    feed(mkw(2'b11, 40'h34)); pol(5, 2);
    feed(mkw(2'b01, 40'h12)); pol(0, 1);
    feed(mkw(2'b11, 40'h13)); pol(0, 1);
    run(2000, 0, 1, 1, 0);
    chk("err_directed", 65'(err_cnt), 65'(m_err));

    // Errors: stray word, header mid-module, then random traffic.
    feed(mkd(64'h1234));
    feed(mkw(2'b01, 40'h55));
    feed_mod(2);
    feed(mkw(2'b01, 40'h56));
    feed_mod(1);
    feed(mkw(2'b11, 40'h56));
    for (int e = 0; e < 40; e++) begin
      l0 = 40'($urandom);
      r = $urandom_range(0, 9);
      if (r == 0) feed(mkd({$urandom, $urandom}));
      if (r == 1) feed({1'b1, 2'b00, 30'($urandom), 32'($urandom)});
      feed(mkw(2'b01, l0));
      for (int m = 0; m < $urandom_range(1, 2); m++)
        feed_mod($urandom_range(0, 3));
      nofoot = (r == 2) && (e != 39);
      if (!nofoot) feed(mkw(2'b11, (r == 3) ? (l0 ^ 40'h1) : l0));
    end
    run(20000, 1, 0, 1, 0);
    chk("err_random", 65'(err_cnt), 65'(m_err));
`ifdef CER_L0ID_CHECK_EN
    chk("mismatch_set", 65'(l0id_mismatch), 65'(m_mism));
`endif

    // Reset in the middle of a forwarded module.
    feed(mkw(2'b01, 40'h77)); pol(0, 2);
    feed_mod(6);              pol(0, 1);
    run(500, 0, 0, 0, 1);
    chk("mid_mod", 65'(bus.evt_available), 65'(M_AV));
    @(negedge clk);
    srst = 1'b1;
    @(negedge clk);
    #1;
    chk("srst_rd_en", 65'(bus.fifo_rd_en), 65'd0);
    chk("srst_av", 65'(bus.evt_available), 65'd0);
    chk("srst_l0id", 65'(bus.evt_l0id), 65'd0);
    chk("srst_valid", 65'(bus.out_valid), 65'd0);
    chk("srst_data", bus.out_data, 65'd0);
    chk("srst_err", 65'(err_cnt), 65'd0);
`ifdef CER_L0ID_CHECK_EN
    chk("srst_mismatch", 65'(l0id_mismatch), 65'd0);
`endif
    clear_tb();
    @(negedge clk);
    srst = 1'b0;

    // Error counter saturation.
    for (int i = 0; i < 65540; i++) feed(mkd(64'(i)));
    run(70000, 0, 0, 0, 0);
    chk("err_sat", 65'(err_cnt),
        65'((m_err > 65535) ? 65535 : m_err));

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end
endmodule
